pcm_sample_fifo: RTL and testbench



---
 rtl/pcm_sample_fifo_pkg.sv | 12 +
 rtl/pcm_peak_tracker.sv | 21 ++
 rtl/pcm_sample_fifo.sv | 73 +++++++
 tb/tb_pcm_sample_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pcm_sample_fifo_pkg.sv
// pcm_sample_fifo_pkg: shared PCM widths, sample type and saturating |x| helper.
package pcm_sample_fifo_pkg;
  localparam int PCM_WIDTH = 16;
  localparam int PCM_FIFO_DEPTH = 8;
  typedef logic signed [15:0] pcm_sample_t;
  // The most negative sample has no positive twin, so it clamps to the largest magnitude
  function automatic logic [PCM_WIDTH-1:0] sat_abs(input pcm_sample_t s);
    logic [PCM_WIDTH-1:0] n;
    n = PCM_WIDTH'(-s);
    return !s[PCM_WIDTH-1] ? PCM_WIDTH'(s) : (n[PCM_WIDTH-1] ? {1'b0, {(PCM_WIDTH-1){1'b1}}} : n);
  endfunction
endpackage

// File: rtl/pcm_peak_tracker.sv
// pcm_peak_tracker: running maximum |sample| over accepted pushes, clearable.
module pcm_peak_tracker
  import pcm_sample_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 clr,
  input  pcm_sample_t          sample,
  output logic [PCM_WIDTH-1:0] peak
);
  logic [PCM_WIDTH-1:0] peak_q, peak_d, mag;
  always_comb begin
    mag = sat_abs(sample);
    peak_d = clr ? (push ? mag : '0) : ((push && mag > peak_q) ? mag : peak_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) peak_q <= '0;
    else peak_q <= peak_d;
  assign peak = peak_q;
endmodule

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: FWFT PCM sample buffer with level, sticky overflow and threshold irq.
// Define PCM_SAMPLE_FIFO_PEAK_EN to add the peak-magnitude tracker (peak_clr / peak).
module pcm_sample_fifo
  import pcm_sample_fifo_pkg::*;
#(
  parameter int DEPTH = PCM_FIFO_DEPTH,
  parameter int WIDTH = PCM_WIDTH,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
  input  logic             peak_clr,
  output logic [WIDTH-1:0] peak,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             ovf_clr,
  input  logic [LVL_W-1:0] threshold,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             irq
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic ovf_q, ovf_d, irq_q, irq_d, pop_ok, push_ok, drop;
  always_comb begin
    empty = level_q == '0;
    full = level_q == LVL_W'(DEPTH);
    pop_ok = rd_en && !empty && !flush;
    // A pop from a full FIFO frees the slot the simultaneous push lands in
    push_ok = in_valid && (!full || pop_ok) && !flush;
    drop = in_valid && full && !pop_ok && !flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop_ok);
    level_d = flush ? '0 : level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    ovf_d = drop || (ovf_q && !ovf_clr);
    irq_d = (threshold != '0) && (level_d >= threshold);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= in_data;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;
  assign overflow = ovf_q;
  assign irq = irq_q;
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
  pcm_peak_tracker u_peak (
    .clk(clk), .rst(rst), .push(push_ok), .clr(peak_clr),
    .sample(pcm_sample_t'(in_data)), .peak(peak)
  );
`endif
endmodule

// File: tb/tb_pcm_sample_fifo.sv
// tb_pcm_sample_fifo: directed plan plus random traffic checked against a queue model.
module tb_pcm_sample_fifo;
  localparam int DEPTH = 8, WIDTH = 16, LVL_W = 4;
  logic clk = 0, rst = 1, in_valid = 0, rd_en = 0, flush = 0, ovf_clr = 0;
  logic [WIDTH-1:0] in_data = 0;
  logic [LVL_W-1:0] threshold = 0;
  logic [WIDTH-1:0] rd_data;
  logic empty, full, overflow, irq;
  logic [LVL_W-1:0] level;
  int checks = 0, errors = 0;
  logic [WIDTH-1:0] q[$];
  logic m_ovf = 0, m_irq = 0;
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
  logic peak_clr = 0;
  logic [WIDTH-1:0] peak;
  int m_peak = 0;
`endif

  pcm_sample_fifo dut (
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
    .peak_clr(peak_clr), .peak(peak),
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .rd_en(rd_en),
    .flush(flush), .ovf_clr(ovf_clr), .threshold(threshold), .rd_data(rd_data),
    .empty(empty), .full(full), .level(level), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level", 32'(level), q.size());
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("irq", 32'(irq), 32'(m_irq));
    check("rd_data", 32'(rd_data), q.size() ? 32'(q[0]) : 0);
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
    check("peak", 32'(peak), m_peak);
`endif
  endtask

  function automatic int mag(input logic [WIDTH-1:0] d);
    int v;
    v = int'($signed(d));
    v = v < 0 ? -v : v;
    return v > 32767 ? 32767 : v;
  endfunction

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f, input logic c);
    bit pop, acc;
    in_valid = v; in_data = d; rd_en = r; flush = f; ovf_clr = c;
    @(posedge clk);
    acc = 0;
    if (f) q.delete();
    else begin
      pop = r && q.size() > 0;
      acc = v && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    m_ovf = (v && !acc && !f) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_irq = threshold != 0 && q.size() >= int'(threshold);
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
    if (peak_clr) m_peak = acc ? mag(d) : 0;
    else if (acc && mag(d) > m_peak) m_peak = mag(d);
`endif
    #1;
    in_valid = 0; rd_en = 0; flush = 0; ovf_clr = 0;
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
    peak_clr = 0;
`endif
    check_all();
  endtask

  task automatic push(input logic [WIDTH-1:0] d); step(1, d, 0, 0, 0); endtask
  task automatic pop(); step(0, 0, 1, 0, 0); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_all();
    push(16'h0001); push(16'h0002); push(16'h0003);
    check("t1_level", 32'(level), 3);
    check("t1_head", 32'(rd_data), 32'h0001);
    for (int i = 1; i <= 3; i++) begin
      check("t1_read", 32'(rd_data), i);
      pop();
    end
    check("t1_empty", 32'(empty), 1);
    check("t1_rd0", 32'(rd_data), 0);
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    push(16'h2000);
    check("t2_full", 32'(full), 1);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_level", 32'(level), 8);
    check("t2_head", 32'(rd_data), 32'h1000);
    step(0, 0, 0, 0, 1);
    check("t2_ovfclr", 32'(overflow), 0);
    step(1, 16'h3000, 1, 0, 0);
    check("t3_level", 32'(level), 8);
    check("t3_ovf", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) pop();
    check("t3_last", 32'(rd_data), 32'h3000);
    pop();
    threshold = 4;
    for (int i = 0; i < 4; i++) begin
      push(16'h4000 + 16'(i));
      check("t4_irq_rise", 32'(irq), 32'(i == 3));
    end
    pop();
    check("t4_irq_fall", 32'(irq), 0);
    step(0, 0, 0, 1, 0);
    threshold = 0;
    for (int i = 0; i < 8; i++) begin
      push(16'h5000 + 16'(i));
      check("t4_irq_off", 32'(irq), 0);
    end
    push(16'h5555);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) push(16'h6000 + 16'(i));
    step(1, 16'h6666, 1, 1, 0);
    check("t5_level", 32'(level), 0);
    check("t5_empty", 32'(empty), 1);
    check("t5_ovf", 32'(overflow), 1);
    threshold = 4;
    for (int i = 0; i < 6; i++) push(16'h7000 + 16'(i));
    check("t6_pre_irq", 32'(irq), 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    q.delete(); m_ovf = 0; m_irq = 0;
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
    m_peak = 0;
`endif
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_irq", 32'(irq), 0);
    check("t6_rst_ovf", 32'(overflow), 0);
    check_all();
    @(posedge clk);
    #1 rst = 0;
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
    push(16'h8000); push(16'd100);
    check("peak_sat", 32'(peak), 32767);
    peak_clr = 1;
    step(0, 0, 1, 0, 0);
    check("peak_clr", 32'(peak), 0);
`endif
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) threshold = LVL_W'($urandom_range(0, 15));
`ifdef PCM_SAMPLE_FIFO_PEAK_EN
      peak_clr = $urandom_range(0, 31) == 0;
`endif
      step($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
